// File: rtl/fiber_pkg.sv
// Shared types for the fiber DRAM responder: request-type codes, responder
// FSM states and the default-width request record.
package fiber_pkg;

  localparam int FIBER_DATA_WIDTH  = 16;
  localparam int FIBER_INDEX_WIDTH = 10;

  typedef enum logic [1:0] {
    REQ_FETCH   = 2'd0,
    REQ_READ    = 2'd1,
    REQ_WRITE   = 2'd2,
    REQ_CONSUME = 2'd3
  } fiber_req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } fiber_rsp_state_e;

  typedef struct packed {
    logic [FIBER_INDEX_WIDTH-1:0] index;
    logic [FIBER_DATA_WIDTH-1:0]  data;
    logic                         write;
  } fiber_req_t;

endpackage

// File: rtl/fiber_req_fifo.sv
// Synchronous request FIFO with registered occupancy count; pointers wrap
// naturally because DEPTH is a power of two.
module fiber_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // payload storage needs no reset; only counted entries are ever read
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fiber_dram_responder.sv
// In-order DRAM-side responder with fixed access latency over a line memory.
// Define FIBER_DRAM_WRITE_ACK_EN to return an acknowledge beat for writes.
module fiber_dram_responder
  import fiber_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 64,
  parameter int MEM_DEPTH   = 1024,
  parameter int LATENCY     = 8,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_nreset,
  input  logic [ADDR_WIDTH-1:0]              i_req_addr,
  input  logic [DATA_WIDTH-1:0]              i_req_data,
  input  logic                               i_req_write,
  input  logic                               i_req_valid,
  output logic                               o_req_ready,
  output logic [DATA_WIDTH-1:0]              o_rsp_data,
  output logic                               o_rsp_valid,
  input  logic                               i_rsp_ready,
  output logic [$clog2(QUEUE_DEPTH+1):0]     o_pending
);

  localparam int OFF_W = $clog2(DATA_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int LAT_W = $clog2(LATENCY);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 2);

`ifdef FIBER_DRAM_WRITE_ACK_EN
  localparam bit WRITE_ACK_EN = 1'b1;
`else
  localparam bit WRITE_ACK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IDX_W-1:0]      index;
    logic [DATA_WIDTH-1:0] data;
    logic                  write;
  } req_t;

  fiber_rsp_state_e      state_q, state_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  req_t                  cur_q, cur_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  mem_we_s;

  req_t                  req_in_s, head_s;
  logic                  push_s, pop_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic                  busy_s;
  logic                  unused_addr_bits_s;

  // higher address bits alias onto the same line
  assign req_in_s.index = i_req_addr[OFF_W +: IDX_W];
  assign req_in_s.data  = i_req_data;
  assign req_in_s.write = i_req_write;
  assign unused_addr_bits_s = ^{i_req_addr[ADDR_WIDTH-1:OFF_W+IDX_W], i_req_addr[OFF_W-1:0]};

  assign o_req_ready = !fifo_full_s;
  assign push_s      = i_req_valid && !fifo_full_s;
  assign busy_s      = (state_q != ST_IDLE);
  assign o_pending   = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, busy_s};
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign mem_rdata_s = mem_q[cur_q.index];

  fiber_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_nreset),
    .push_i  (push_s),
    .data_i  (req_in_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // FSM and response registers
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) state_d = ST_ACCESS;
        else               state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        if (cnt_q != '0)                         state_d = ST_ACCESS;
        else if (cur_q.write && !WRITE_ACK_EN)   state_d = ST_IDLE;
        else                                     state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        // popping on the handshake keeps back-to-back reads at one per LATENCY
        if (!i_rsp_ready)       state_d = ST_RESPOND;
        else if (!fifo_empty_s) state_d = ST_ACCESS;
        else                    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath controls
  always_comb begin
    pop_s       = 1'b0;
    mem_we_s    = 1'b0;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          cnt_d = LAT_LOAD;
          cur_d = head_s;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else if (!cur_q.write) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_rdata_s;
        end else begin
          mem_we_s = 1'b1;
          if (WRITE_ACK_EN) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = cur_q.data;
          end else begin
            rsp_valid_d = 1'b0;
          end
        end
      end
      ST_RESPOND: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty_s) begin
            pop_s = 1'b1;
            cnt_d = LAT_LOAD;
            cur_d = head_s;
          end else begin
            pop_s = 1'b0;
          end
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // line memory survives reset so committed writes are retained
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_q[cur_q.index] <= cur_q.data;
    end
  end

endmodule

// File: tb/tb_fiber_dram_responder.sv
// Bench for fiber_dram_responder: timing/data reference model checked every
// cycle plus directed scenarios with literal expectations.
module tb_fiber_dram_responder;

  localparam int LAT = 8;
  localparam int QD  = 4;
`ifdef FIBER_DRAM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_nreset = 1'b0;
  logic [63:0] i_req_addr = 64'd0;
  logic [15:0] i_req_data = 16'd0;
  logic        i_req_write = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [15:0] o_rsp_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [3:0]  o_pending;

  fiber_dram_responder #(
    .DATA_WIDTH(16), .ADDR_WIDTH(64), .MEM_DEPTH(1024), .LATENCY(LAT), .QUEUE_DEPTH(QD)
  ) dut (
    .i_clk(i_clk), .i_nreset(i_nreset), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_req_write(i_req_write), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 4) & 64'h3FF);
  endfunction

  // Reference model: in-order server, start = max(accept+1, server free),
  // access edge = start + LAT - 1; beats free the server on their handshake.
  typedef struct { int edge_n; bit wr; int idx; logic [15:0] data; } req_s;
  req_s             acc_q[$];
  req_s             act_r;
  bit               act = 1'b0, act_done = 1'b0, act_known = 1'b0;
  int               act_s = 0, act_x = 0, free_e = 0;
  logic [15:0]      act_exp = 16'd0;
  logic [15:0]      ref_mem [int];
  logic [15:0]      beats[$];
  int               beat_cyc[$];
  bit               m_exp_v;
  int               m_fcnt;

  always @(negedge i_clk) begin
    m_exp_v = 1'b0;
    if (!i_nreset) begin
      acc_q.delete();
      act    = 1'b0;
      free_e = 0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (!act && acc_q.size() > 0) begin
          act_r    = acc_q.pop_front();
          act      = 1'b1;
          act_done = 1'b0;
          act_s    = (act_r.edge_n + 1 > free_e) ? act_r.edge_n + 1 : free_e;
          act_x    = act_s + LAT - 1;
        end else if (act && act_r.wr && !ACK && cyc >= act_x) begin
          ref_mem[act_r.idx] = act_r.data;
          act    = 1'b0;
          free_e = act_x + 1;
        end
      end
      if (act && (!act_r.wr || ACK) && cyc >= act_x && !act_done) begin
        act_done = 1'b1;
        if (act_r.wr) begin
          ref_mem[act_r.idx] = act_r.data;
          act_exp = act_r.data;
          act_known = 1'b1;
        end else if (ref_mem.exists(act_r.idx)) begin
          act_exp = ref_mem[act_r.idx];
          act_known = 1'b1;
        end else begin
          act_known = 1'b0;
        end
      end
      m_exp_v = act && act_done;
    end
    m_fcnt = acc_q.size() + ((act && cyc < act_s) ? 1 : 0);
    chk("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, m_exp_v});
    if (m_exp_v && act_known) chk("rsp_data", {16'd0, o_rsp_data}, {16'd0, act_exp});
    chk("pending", {28'd0, o_pending}, acc_q.size() + int'(act));
    chk("req_ready", {31'd0, o_req_ready}, {31'd0, m_fcnt < QD});
    if (o_rsp_valid && i_rsp_ready) begin
      beats.push_back(o_rsp_data);
      beat_cyc.push_back(cyc);
    end
    if (m_exp_v && i_rsp_ready) begin
      act    = 1'b0;
      free_e = cyc + 1;
    end
    if (i_nreset && i_req_valid && m_fcnt < QD)
      acc_q.push_back('{cyc + 1, i_req_write, idx_of(i_req_addr), i_req_data});
  end

  task automatic send(input logic [63:0] a, input logic [15:0] d, input bit w, output int acc);
    int n = 0;
    bit rdy = 1'b0;
    i_req_addr = a; i_req_data = d; i_req_write = w; i_req_valid = 1'b1;
    do begin
      @(negedge i_clk);
      rdy = o_req_ready;
      @(posedge i_clk); #1;
      n++;
    end while (!rdy && n < 100);
    i_req_valid = 1'b0;
    acc = cyc;
    if (!rdy) timeout("send");
  endtask

  task automatic wait_valid(output int at);
    int n = 0;
    at = -1;
    while (n < 200 && at < 0) begin
      @(negedge i_clk);
      if (o_rsp_valid) at = cyc;
      n++;
    end
    if (at < 0) timeout("wait_valid");
  endtask

  task automatic wait_idle();
    int n = 0;
    bit done = 1'b0;
    while (n < 400 && !done) begin
      @(negedge i_clk);
      if (o_pending == 4'd0 && !o_rsp_valid) done = 1'b1;
      n++;
    end
    if (!done) timeout("wait_idle");
    @(posedge i_clk); #1;
  endtask

  logic [15:0] exp5 [5];
  int acc, at, b0, dummy;

  initial begin
    exp5 = '{16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
    repeat (3) @(posedge i_clk);
    #1 i_nreset = 1'b1;
    chk("reset_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_data", {16'd0, o_rsp_data}, 32'd0);
    chk("reset_pending", {28'd0, o_pending}, 32'd0);
    chk("reset_ready", {31'd0, o_req_ready}, 32'd1);

    // latency of an unobstructed read
    send(64'h30, 16'h1234, 1'b1, dummy);
    wait_idle();
    send(64'h30, 16'h0000, 1'b0, acc);
    wait_valid(at);
    chk("read_latency", at - acc, 32'd8);
    chk("read_data", {16'd0, o_rsp_data}, 32'h1234);
    wait_idle();

    // read-after-write, optional write beat
    b0 = beats.size();
    send(64'h40, 16'hBEEF, 1'b1, dummy);
    send(64'h40, 16'h0000, 1'b0, dummy);
    wait_idle();
    chk("wr_rd_beats", beats.size() - b0, ACK ? 32'd2 : 32'd1);
    chk("wr_rd_data", {16'd0, beats[$]}, 32'hBEEF);

    // fill the queue with the inbox stalled
    i_rsp_ready = 1'b0;
    b0 = beats.size();
    for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 64'h30 : 64'h40, 16'h0000, 1'b0, dummy);
    @(negedge i_clk);
    chk("full_ready", {31'd0, o_req_ready}, 32'd0);
    chk("full_pending", {28'd0, o_pending}, 32'd5);
    @(posedge i_clk); #1 i_rsp_ready = 1'b1;
    wait_idle();
    chk("full_beats", beats.size() - b0, 32'd5);
    for (int i = 0; i < 5; i++)
      if (b0 + i < beats.size()) chk("full_order", {16'd0, beats[b0 + i]}, {16'd0, exp5[i]});

    // 10-cycle hold in RESPOND
    i_rsp_ready = 1'b0;
    b0 = beats.size();
    send(64'h40, 16'h0000, 1'b0, dummy);
    wait_valid(at);
    repeat (10) begin
      @(negedge i_clk);
      chk("hold_valid", {31'd0, o_rsp_valid}, 32'd1);
      chk("hold_data", {16'd0, o_rsp_data}, 32'hBEEF);
    end
    @(posedge i_clk); #1 i_rsp_ready = 1'b1;
    wait_idle();
    chk("hold_beats", beats.size() - b0, 32'd1);

    // address aliasing onto one line
    send(64'h10, 16'h5A5A, 1'b1, dummy);
    send(64'h4010, 16'h0000, 1'b0, dummy);
    wait_idle();
    chk("alias_data", {16'd0, beats[$]}, 32'h5A5A);

    // back-to-back spacing
    b0 = beats.size();
    send(64'h30, 16'h0000, 1'b0, acc);
    send(64'h40, 16'h0000, 1'b0, dummy);
    send(64'h10, 16'h0000, 1'b0, dummy);
    wait_idle();
    chk("b2b_count", beats.size() - b0, 32'd3);
    if (beats.size() >= b0 + 3) begin
      chk("b2b_first", beat_cyc[b0] - acc, 32'd8);
      chk("b2b_gap1", beat_cyc[b0 + 1] - beat_cyc[b0], 32'd8);
      chk("b2b_gap2", beat_cyc[b0 + 2] - beat_cyc[b0 + 1], 32'd8);
      chk("b2b_data", {16'd0, beats[b0 + 2]}, 32'h5A5A);
    end

    // reset in the middle of an access
    send(64'h30, 16'h0000, 1'b0, dummy);
    send(64'h40, 16'h0000, 1'b0, dummy);
    send(64'h10, 16'h0000, 1'b0, dummy);
    @(negedge i_clk);
    chk("pre_reset_pending", {28'd0, o_pending}, 32'd3);
    @(posedge i_clk); #1 i_nreset = 1'b0;
    #1;
    chk("mid_reset_pending", {28'd0, o_pending}, 32'd0);
    chk("mid_reset_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("mid_reset_ready", {31'd0, o_req_ready}, 32'd1);
    @(posedge i_clk); #1 i_nreset = 1'b1;
    b0 = beats.size();
    send(64'h10, 16'h0000, 1'b0, dummy);
    wait_idle();
    chk("post_reset_beats", beats.size() - b0, 32'd1);
    chk("post_reset_data", {16'd0, beats[$]}, 32'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
